// File: rtl/psum_drain.sv
// Drains final psum vectors from the core's SRAM into a small vector FIFO and
// serializes them one psum word per beat. Define PSUM_DRAIN_RELU_EN to clamp negative words to 0.
module psum_drain #(
  parameter int psum_bw = 32,
  parameter int col     = 8,
  parameter int depth   = 4,
  parameter int cnt_bw  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [cnt_bw-1:0]      num_vec,
  output logic                   vec_rd_en,
  input  logic [psum_bw*col-1:0] vec_in,
  output logic [psum_bw-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int aw = $clog2(depth);
  localparam int lw = (col > 1) ? $clog2(col) : 1;
  localparam int vw = psum_bw * col;
  localparam logic [aw:0]   depth_v = (aw + 1)'(depth);
  localparam logic [lw-1:0] lane_max = lw'(col - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [cnt_bw-1:0] num_vec_q;
  logic [cnt_bw-1:0] issued;
  logic [cnt_bw-1:0] popped;
  logic              inflight;
  logic [aw:0]       fifo_count;
  logic [aw-1:0]     wr_ptr;
  logic [aw-1:0]     rd_ptr;
  logic [lw-1:0]     lane_idx;
  logic [vw-1:0]     mem [depth];

  logic [aw:0]        occupancy;
  logic [vw-1:0]      head;
  logic [psum_bw-1:0] word;
  logic               lane_end;
  logic               hs;
  logic               push;
  logic               pop;

  // Read credit counts the vector still in flight so the FIFO can never overflow.
  always_comb begin
    occupancy = fifo_count + (aw + 1)'(inflight);
    vec_rd_en = (state == DRAIN) && (issued < num_vec_q) && (occupancy < depth_v);
    out_valid = (fifo_count != '0);
    head      = mem[rd_ptr];
    word      = head[lane_idx*psum_bw +: psum_bw];
`ifdef PSUM_DRAIN_RELU_EN
    out_data  = word[psum_bw-1] ? '0 : word;
`else
    out_data  = word;
`endif
    lane_end  = (lane_idx == lane_max);
    out_last  = out_valid && lane_end && (popped == num_vec_q - cnt_bw'(1));
    hs        = out_valid && out_ready;
    push      = inflight && (state == DRAIN);
    pop       = hs && lane_end;
  end

  assign busy = (state == DRAIN);

  // NOTE: the FIFO storage is reset so out_data reads 0 out of reset; this costs
  // a reset on every entry bit, which is acceptable at this small depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= vec_in;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates see
  // the same pre-edge values of the combinational handshake terms above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      num_vec_q  <= '0;
      issued     <= '0;
      popped     <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lane_idx   <= '0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= vec_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_vec == '0) begin
              done <= 1'b1;
            end else begin
              state      <= DRAIN;
              num_vec_q  <= num_vec;
              issued     <= '0;
              popped     <= '0;
              fifo_count <= '0;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              lane_idx   <= '0;
            end
          end
        end
        DRAIN: begin
          if (vec_rd_en) issued <= issued + cnt_bw'(1);
          if (push) wr_ptr <= wr_ptr + aw'(1);
          if (hs) lane_idx <= lane_end ? '0 : lane_idx + lw'(1);
          if (pop) begin
            rd_ptr <= rd_ptr + aw'(1);
            popped <= popped + cnt_bw'(1);
          end
          if (push && !pop)      fifo_count <= fifo_count + (aw + 1)'(1);
          else if (!push && pop) fifo_count <= fifo_count - (aw + 1)'(1);
          if (hs && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psum_drain.md
# psum_drain

Output drain stage downstream of the psum core. Once all accumulation passes finish, it sequences reads of the final psum vectors out of the core's psum SRAM bank using a dump-mode read strobe. It buffers each returned `psum_bw*col` vector in a small FIFO and serializes it into one `psum_bw` word per channel on a valid/ready stream toward the host/testbench.

## Interface

**Parameters**
- `psum_bw`, default 32: psum word width.
- `col`, default 8: channels per vector.
- `depth`, default 4: vector FIFO entries. Must be a power of 2 and at least 2.
- `cnt_bw`, default 11: width of vector count and pointers.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a drain. Sampled only in IDLE.
- `num_vec` in `cnt_bw`: number of vectors to drain. Latched on the accepted `start`.
- `vec_rd_en` out 1: dump-mode read request to the core. One vector per asserted cycle.
- `vec_in` in `psum_bw*col`: core's final psum vector. Valid exactly one cycle after `vec_rd_en`.
- `out_data` out `psum_bw`: serialized psum word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word.
- `out_last` out 1: qualifies the final word of the drain.
- `busy` out 1: high in DRAIN.
- `done` out 1: one-cycle pulse at drain completion.

## Operation

- **FSM states:** IDLE, DRAIN.
- **IDLE to DRAIN:** on `start`=1. `num_vec` is latched, and the issue counter, return counter, word counter and lane index are cleared.
- **`start` with `num_vec`=0:** the FSM stays in IDLE and `done` pulses in the next cycle. No reads are issued.
- **`start` while in DRAIN:** ignored.
- **Issue rule:** `vec_rd_en` = DRAIN and (issued < `num_vec`) and (fifo_count + inflight < `depth`).
  - `inflight` is 1 if `vec_rd_en` was asserted in the previous cycle, otherwise 0.
  - The FIFO therefore never overflows. `vec_in` is always written unconditionally in the cycle after a read.
- **FIFO:** `depth` entries of `psum_bw*col`.
  - Write and read pointers are log2(`depth`) bits and wrap naturally.
  - Simultaneous write and pop leaves the count unchanged.
- **Serializer:**
  - `out_valid` = FIFO not empty.
  - `out_data` = lane `lane_idx` of the FIFO head, with lane k = bits [k*psum_bw +: psum_bw]. Lane 0 goes first.
  - On handshake (`out_valid` and `out_ready`), `lane_idx` increments.
  - At `lane_idx` = `col`-1 the head is popped and `lane_idx` wraps to 0.
- **`out_last`:** `out_valid` and (`lane_idx` = `col`-1) and (popped vectors = `num_vec`-1).
- **Completion:** the handshake on the `out_last` word moves the FSM to IDLE, and `done` pulses in the following cycle.
- **`out_ready` low:** `out_data`, `out_valid`, `out_last` and `lane_idx` hold. Issue continues until the FIFO credit is exhausted.
- **Reset mid-drain:** returns to IDLE and clears the FIFO and all counters. Read data still in flight is discarded, because the write is gated by DRAIN.

## Timing

- **Reset values:** `vec_rd_en`=0, `out_valid`=0, `out_data`=0 (FIFO entries are reset to 0), `out_last`=0, `busy`=0, `done`=0.
- **Start:** `start` high in cycle T gives `busy` and the first `vec_rd_en` in T+1.
- **Read latency:** `vec_rd_en` in cycle C means `vec_in` is captured at the end of C+1. The first `out_valid` is in C+2.
- **Throughput:** with `out_ready` held high, the stream sustains one word per cycle with no bubbles between vectors. A drain of N vectors produces N*`col` words in N*`col`+2 cycles after the first issue.
- **Done timing:** `done` asserts the cycle after the last handshake. `busy` falls in that same cycle.

## Configuration

- **`PSUM_DRAIN_RELU_EN` defined:** each serialized word is treated as signed. A negative word becomes 0 on `out_data`; positive and zero words pass unchanged.
- **`PSUM_DRAIN_RELU_EN` undefined:** `out_data` passes the raw psum bits.
- **Either setting:** FIFO contents and all timing are identical.

## Test plan

- **Basic drain.** Stimulus: `num_vec`=2, `out_ready`=1, vec0 lanes = 0..7, vec1 lanes = 8..15. Required response: words 0..15 in order, `out_last` only on word 15, and `done` one cycle after it.
- **Backpressure.** Stimulus: `num_vec`=8, `depth`=4, `out_ready`=0 for 20 cycles after start. Required response: exactly 4 `vec_rd_en` pulses, the FIFO holds 4 entries, `out_data` stays stable at lane 0 of vec0, and all 64 words arrive after release.
- **Zero count.** Stimulus: `start` with `num_vec`=0. Required response: no `vec_rd_en`, `done` pulses in T+1, `busy` stays 0.
- **Reset mid-drain.** Stimulus: reset asserted after 5 accepted words of a 4-vector drain. Required response: all outputs go to 0 the next cycle. A fresh drain with `num_vec`=1 then starts from lane 0 of new data.
- **ReLU.** Stimulus: a lane holding 32'hFFFF_FFF6 (-10) and a lane holding 32'd10. Required response: with `PSUM_DRAIN_RELU_EN` defined, outputs are 0 and 10; without it, outputs are 32'hFFFF_FFF6 and 10.
- **Ignored start.** Stimulus: `start` pulsed in the middle of a drain. Required response: no change to the count and no extra reads.
